mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 144 ++++++++++++++
 tb/tb_mdu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// mdu_seq : iterative multiply/divide unit with hi/lo result registers
// Revision: 1.0
// ============================================================================
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_calc  = 2'd1;
    localparam logic [1:0] c_fixup = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi_acc;
    logic [WIDTH-1:0]   r_lo_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign busy = (r_state == c_calc) || (r_state == c_fixup);
    assign done = (r_state == c_done);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Signed ops run on magnitudes; signs are restored in FIXUP.
    assign w_sign_a = ~op[0] & srca[WIDTH-1];
    assign w_sign_b = ~op[0] & srcb[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -srca : srca;
    assign w_mag_b  = w_sign_b ? -srcb : srcb;

    assign w_add   = {1'b0, r_hi_acc} + ({(WIDTH+1){r_lo_acc[0]}} & {1'b0, r_b});
    assign w_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    assign w_prod     = {r_hi_acc, r_lo_acc};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    // A zero divisor leaves |dividend| as remainder, so the sign fix returns srca.
    assign w_quo      = (r_b == '0) ? '1 : (r_neg_q ? -r_lo_acc : r_lo_acc);
    assign w_rem      = r_neg_r ? -r_hi_acc : r_hi_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b      <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_state  <= c_calc;
                        r_cnt    <= '0;
                        r_div    <= op[1];
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_hi_acc <= '0;
                        r_b      <= op[1] ? w_mag_b : w_mag_a;
                        r_lo_acc <= op[1] ? w_mag_a : w_mag_b;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                c_calc: begin
                    if (cancel) begin
                        r_state <= c_idle;
                    end else begin
                        if (r_div) begin
                            r_hi_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                            r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_ge};
                        end else begin
                            r_hi_acc <= w_add[WIDTH:1];
                            r_lo_acc <= {w_add[0], r_lo_acc[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= c_fixup;
                        end
                    end
                end
                c_fixup: r_state <= cancel ? c_idle : c_done;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Result commit wins over direct writes; direct writes only while not busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == c_fixup) && !cancel) begin
            r_hi <= r_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= r_div ? w_quo : w_prod_fix[WIDTH-1:0];
        end else if (!busy) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mdu_seq : directed self-checking bench for mdu_seq
// Revision: 1.0
// ============================================================================
module tb_mdu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .cancel  (cancel),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Pulse start for one accepting edge, then scramble operands to prove latching.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        srca  = ~a;
        srcb  = ~b;
        op    = ~o;
    endtask

    // Returns the cycle (1 = first after accept) where done is seen, 0 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic write_hilo(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        @(posedge clk);
        #1;
        hi_we = 1'b1;
        wdata = h;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = l;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_multu();
        int busy_bad = 0;
        int done_bad = 0;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
        end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL multu_busy_1_33: got %0d bad cycles want 0", busy_bad); end
        total++; if (done_bad != 0) begin bad++; $display("FAIL multu_done_early: got %0d early cycles want 0", done_bad); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL multu_done_c34: got %b want 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_c34: got %b want 0", busy); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_c35: got %b want 0", done); end
    endtask

    task automatic test_signed();
        int cyc;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc);
        total++; if (cyc != 34) begin bad++; $display("FAIL mult_latency: got %0d want 34", cyc); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    endtask

    task automatic test_div_edges();
        int cyc;
        issue(2'b11, 32'd100, 32'd0);
        wait_done(cyc);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'h0000_0064) begin bad++; $display("FAIL divu0_hi: got %h want 00000064", hi); end
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0);
        wait_done(cyc);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'hFFFF_FFF9) begin bad++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divmin_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL divmin_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_busy_inputs();
        int cyc;
        write_hilo(32'h55, 32'h66);
        total++; if (hi !== 32'h55) begin bad++; $display("FAIL mthi_idle: got %h want 00000055", hi); end
        issue(2'b11, 32'd10, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        op = 2'b01; srca = 32'd2; srcb = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        total++; if (hi !== 32'h55) begin bad++; $display("FAIL mthi_busy: got %h want 00000055", hi); end
        wait_done(cyc);
        total++; if (cyc == 0) begin bad++; $display("FAIL divu_done_timeout: got no done want done"); end
        total++; if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo: got %h want 00000003", lo); end
        total++; if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(2'b01, 32'd5, 32'd9);
        wait_done(cyc);
        issue(2'b01, 32'd6, 32'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(cyc);
        total++; if (cyc != 34) begin bad++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL b2b_lo: got %h want 0000002a", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL b2b_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_cancel();
        int cyc;
        write_hilo(32'h11, 32'h22);
        issue(2'b01, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", busy); end
        wait_done(cyc);
        total++; if (cyc != 0) begin bad++; $display("FAIL cancel_done: got done at %0d want none", cyc); end
        total++; if (hi !== 32'h11) begin bad++; $display("FAIL cancel_hi: got %h want 00000011", hi); end
        total++; if (lo !== 32'h22) begin bad++; $display("FAIL cancel_lo: got %h want 00000022", lo); end
        cancel = 1'b1;
        issue(2'b01, 32'd3, 32'd4);
        cancel = 1'b0;
        wait_done(cyc);
        total++; if (cyc != 34) begin bad++; $display("FAIL start_cancel_latency: got %0d want 34", cyc); end
        total++; if (lo !== 32'd12) begin bad++; $display("FAIL start_cancel_lo: got %h want 0000000c", lo); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        write_hilo(32'h77, 32'h88);
        issue(2'b01, 32'd9, 32'd9);
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi: got %h want 00000000", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo: got %h want 00000000", lo); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_done(cyc);
        total++; if (cyc != 0) begin bad++; $display("FAIL rst_resume: got done at %0d want none", cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_resume_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_edges();
        test_busy_inputs();
        test_back_to_back();
        test_cancel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
